// File: rtl/veda_mc_core.sv
// veda_mc_core -- multi-cycle Veda core (6-bit opcode ISA) driven by an explicit FSM.
//
// Each instruction walks FETCH -> DECODE -> EXEC -> [MEM] -> WB. Instruction and data
// memories are separate. Both use a req/ready handshake, so wait-state memories work.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   imem_req/addr/ready/rdata instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata    data access request, held stable until dmem_ready
//   dmem_ready/rdata          access complete; load data valid with ready
//   halted                    core parked after HALT (only rst leaves)
//   retire                    one-cycle pulse per retired instruction
//
// Optional feature macro VEDA_MC_CORE_PERF_EN:
//   Adds the saturating 32-bit counters cycle_cnt (non-HALT cycles) and
//   instr_cnt (retired instructions). Both counters clear on rst.
module veda_mc_core #(
  parameter int XLEN     = 32,
  parameter int PC_W     = 9,
  parameter int DA_W     = 9,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [DA_W-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            halted,
  output logic            retire
`ifdef VEDA_MC_CORE_PERF_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [5:0] OP_LW   = 6'd12;
  localparam logic [5:0] OP_SW   = 6'd13;
  localparam logic [5:0] OP_HALT = 6'd31;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  function automatic logic signed [XLEN-1:0] sext16(input logic [15:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic signed [XLEN-1:0] zext16(input logic [15:0] v);
    return XLEN'(v);
  endfunction

  state_t state, state_next;

  logic [PC_W-1:0]        pc, pc_inc, npc, npc_c;
  logic [31:0]            ir;
  logic signed [XLEN-1:0] rf [32];
  logic signed [XLEN-1:0] a, b, res, res_c, wd;
  logic [SH_W-1:0]        sh;
  logic [DA_W-1:0]        ea;
  logic                   taken;
  logic                   wen;
  logic [4:0]             dst;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, rsh;
  logic [15:0] imm;

  assign op  = ir[31:26];
  assign rs  = ir[25:21];
  assign rt  = ir[20:16];
  assign rd  = ir[15:11];
  assign rsh = ir[10:6];
  assign imm = ir[15:0];

  assign pc_inc    = pc + PC_W'(1);
  assign imem_addr = pc;

  // EXEC datapath: ALU result, branch decision, next PC
  always_comb begin
    res_c = '0;
    npc_c = pc_inc;
    taken = 1'b0;
    case (op)
      6'd0, 6'd2: res_c = a + b;
      6'd1, 6'd3: res_c = a - b;
      6'd4:       res_c = a + sext16(imm);
      6'd5:       res_c = a + zext16(imm);
      6'd6:       res_c = a & b;
      6'd7:       res_c = a | b;
      6'd8:       res_c = a & zext16(imm);
      6'd9:       res_c = a | zext16(imm);
      6'd10:      res_c = b << sh;
      6'd11:      res_c = b >> sh;
      6'd14:      taken = (a == b);
      6'd15:      taken = (a != b);
      6'd16:      taken = (a > b);
      6'd17:      taken = (a >= b);
      6'd18:      taken = (a < b);
      6'd19:      taken = (a <= b);
      6'd20:      npc_c = PC_W'(imm);
      6'd21:      npc_c = a[PC_W-1:0];
      6'd22: begin
        npc_c = PC_W'(imm);
        res_c = XLEN'(pc_inc);
      end
      6'd23:      res_c = zext16(imm);
      6'd24:      res_c = (a < b) ? XLEN'(1) : '0;
      OP_HALT:    npc_c = pc;
      default:    ;
    endcase
    // Offset is added modulo 2^PC_W, so only its low PC_W bits matter.
    if (taken) npc_c = pc_inc + PC_W'(imm);
  end

  // Destination select for WB
  always_comb begin
    wen = 1'b0;
    dst = rd;
    case (op)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd6, 6'd7, 6'd10, 6'd11, 6'd24: wen = 1'b1;
      6'd4, 6'd5, 6'd8, 6'd9, OP_LW, 6'd23: begin
        wen = 1'b1;
        dst = rt;
      end
      6'd22: begin
        wen = 1'b1;
        dst = 5'd31;
      end
      default: ;
    endcase
  end

  // FSM next state and handshake outputs; rst forces every output low at once
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    halted     = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = (op == OP_SW);
        dmem_addr  = ea;
        dmem_wdata = wd;
        if (dmem_ready) state_next = S_WB;
      end
      S_WB: begin
        retire     = 1'b1;
        state_next = (op == OP_HALT) ? S_HALT : S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  state_next = S_FETCH;
    endcase
    if (rst) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      halted     = 1'b0;
      retire     = 1'b0;
    end
  end

  // Architectural state: FSM, PC, register file
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= PC_W'(RESET_PC);
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= state_next;
      if (state == S_WB) begin
        pc <= npc;
        if (wen && dst != 5'd0) rf[dst] <= res;
      end
    end
  end

  // Per-stage datapath latches (no reset: always rewritten before use)
  always_ff @(posedge clk) begin
    // FETCH -> DECODE
    if (state == S_FETCH && imem_ready) ir <= imem_rdata;
    // DECODE -> EXEC
    if (state == S_DECODE) begin
      a  <= rf[rs];
      b  <= rf[rt];
      sh <= rf[rsh][SH_W-1:0];
    end
    // EXEC -> MEM/WB
    if (state == S_EXEC) begin
      res <= res_c;
      npc <= npc_c;
      ea  <= DA_W'(a + sext16(imm));
      wd  <= b;
    end
    // MEM -> WB
    if (state == S_MEM && dmem_ready && op == OP_LW) res <= dmem_rdata;
  end

`ifdef VEDA_MC_CORE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= sat_inc(cycle_cnt);
      if (retire) instr_cnt <= sat_inc(instr_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_veda_mc_core.sv
// Directed bench for veda_mc_core: small hand-assembled programs with hand-computed
// results. The bench also provides wait-state instruction and data memories.
module tb_veda_mc_core;
  localparam int PC_W = 9;
  localparam int DA_W = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req, imem_ready = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata = '0;
  logic            dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [DA_W-1:0] dmem_addr;
  logic [31:0]     dmem_wdata, dmem_rdata = '0;
  logic            halted, retire;
`ifdef VEDA_MC_CORE_PERF_EN
  logic [31:0]     cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  veda_mc_core dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .halted(halted), .retire(retire)
`ifdef VEDA_MC_CORE_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  logic [31:0] imem [512];
  logic [31:0] dmem [512];
  int iwait = 0, dwait = 0;
  int n_checks = 0, n_errs = 0;
  int retire_cnt = 0, st_cnt = 0, ld_cnt = 0;
  logic [DA_W-1:0] st_addr = '0, ld_addr = '0;
  logic [31:0]     st_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int op, input int rs, input int rt, input int rd, input int sh);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], 6'd0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] rv(input int i);
    return dut.rf[i];
  endfunction

  // Instruction memory: ready after iwait request cycles; address must not move meanwhile.
  int i_cnt = 0;
  logic i_pend = 1'b0, i_ok = 1'b1;
  logic [PC_W-1:0] i_addr = '0;
  always @(negedge clk) begin
    imem_ready = 1'b0;
    imem_rdata = '0;
    if (imem_req) begin
      if (!i_pend) begin
        i_pend = 1'b1;
        i_ok   = 1'b1;
        i_addr = imem_addr;
      end else if (imem_addr !== i_addr) begin
        i_ok = 1'b0;
      end
      if (i_cnt >= iwait) begin
        imem_ready = 1'b1;
        imem_rdata = imem[imem_addr];
        check("imem_hold", {63'd0, i_ok}, 64'd1);
        i_pend = 1'b0;
        i_cnt  = 0;
      end else begin
        i_cnt++;
      end
    end else begin
      i_pend = 1'b0;
      i_cnt  = 0;
    end
  end

  // Data memory: ready after dwait request cycles; request fields must stay stable.
  int d_cnt = 0;
  logic d_pend = 1'b0, d_ok = 1'b1, d_we = 1'b0;
  logic [DA_W-1:0] d_addr = '0;
  logic [31:0]     d_wdata = '0;
  always @(negedge clk) begin
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    if (rst) begin
      st_cnt = 0;
      ld_cnt = 0;
      d_pend = 1'b0;
      d_cnt  = 0;
    end else if (dmem_req) begin
      if (!d_pend) begin
        d_pend  = 1'b1;
        d_ok    = 1'b1;
        d_addr  = dmem_addr;
        d_we    = dmem_we;
        d_wdata = dmem_wdata;
      end else if (dmem_addr !== d_addr || dmem_we !== d_we || dmem_wdata !== d_wdata) begin
        d_ok = 1'b0;
      end
      if (d_cnt >= dwait) begin
        dmem_ready = 1'b1;
        check("dmem_hold", {63'd0, d_ok}, 64'd1);
        if (dmem_we) begin
          dmem[dmem_addr] = dmem_wdata;
          st_cnt++;
          st_addr = dmem_addr;
          st_data = dmem_wdata;
        end else begin
          dmem_rdata = dmem[dmem_addr];
          ld_cnt++;
          ld_addr = dmem_addr;
        end
        d_pend = 1'b0;
        d_cnt  = 0;
      end else begin
        d_cnt++;
      end
    end else begin
      d_pend = 1'b0;
      d_cnt  = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) retire_cnt = 0;
    else if (retire) retire_cnt++;
  end

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
    end
  endtask

  task automatic run_prog(input int iw, input int dw, input int budget, output int cycles);
    iwait = iw;
    dwait = dw;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk);
      cycles++;
      #1;
      if (halted) break;
    end
    check("halt_reached", {63'd0, halted}, 64'd1);
  endtask

  int cyc;

  initial begin
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", {63'd0, imem_req}, 64'd0);
    check("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_retire", {63'd0, retire}, 64'd0);
    check("rst_pc", 64'(dut.pc), 64'd0);
    check("rst_r5", 64'(rv(5)), 64'd0);

    // li r1,5; li r2,7; add r3,r1,r2; HALT
    imem[0] = enc_i(23, 0, 1, 5);
    imem[1] = enc_i(23, 0, 2, 7);
    imem[2] = enc_r(0, 1, 2, 3, 0);
    imem[3] = enc_i(31, 0, 0, 0);
    run_prog(0, 0, 200, cyc);
    check("t1_cycles", 64'(cyc), 64'd16);
    check("t1_r3", 64'(rv(3)), 64'd12);
    check("t1_retires", 64'(retire_cnt), 64'd4);
    check("t1_pc_frozen", 64'(dut.pc), 64'd3);
`ifdef VEDA_MC_CORE_PERF_EN
    check("t1_cycle_cnt", 64'(cycle_cnt), 64'd16);
    check("t1_instr_cnt", 64'(instr_cnt), 64'd4);
`endif

    // Same program, three fetch wait cycles per instruction
    run_prog(3, 0, 200, cyc);
    check("t2_cycles", 64'(cyc), 64'd28);
    check("t2_r3", 64'(rv(3)), 64'd12);
    check("t2_retires", 64'(retire_cnt), 64'd4);

    // li r16,100; li r5,42; sw r5,4(r16); lw r6,4(r16); HALT with 2 data wait cycles
    clear_mem();
    imem[0] = enc_i(23, 0, 16, 100);
    imem[1] = enc_i(23, 0, 5, 42);
    imem[2] = enc_i(13, 16, 5, 4);
    imem[3] = enc_i(12, 16, 6, 4);
    imem[4] = enc_i(31, 0, 0, 0);
    run_prog(0, 2, 200, cyc);
    check("t3_cycles", 64'(cyc), 64'd26);
    check("t3_store_cnt", 64'(st_cnt), 64'd1);
    check("t3_store_addr", 64'(st_addr), 64'd104);
    check("t3_store_data", 64'(st_data), 64'd42);
    check("t3_load_cnt", 64'(ld_cnt), 64'd1);
    check("t3_load_addr", 64'(ld_addr), 64'd104);
    check("t3_r6", 64'(rv(6)), 64'd42);

    // li r2,3; loop: addi r1,r1,1; bne r1,r2,-2; HALT
    clear_mem();
    imem[0] = enc_i(23, 0, 2, 3);
    imem[1] = enc_i(4, 1, 1, 1);
    imem[2] = enc_i(15, 1, 2, -2);
    imem[3] = enc_i(31, 0, 0, 0);
    run_prog(0, 0, 200, cyc);
    check("t4_r1", 64'(rv(1)), 64'd3);
    check("t4_retires", 64'(retire_cnt), 64'd8);
    check("t4_pc", 64'(dut.pc), 64'd3);
    check("t4_cycles", 64'(cyc), 64'd32);

    // addi r1,r0,-1; li r2,1; blt r1,r2,+2; li r7,1; HALT; li r8,9; HALT
    clear_mem();
    imem[0] = enc_i(4, 0, 1, -1);
    imem[1] = enc_i(23, 0, 2, 1);
    imem[2] = enc_i(18, 1, 2, 2);
    imem[3] = enc_i(23, 0, 7, 1);
    imem[4] = enc_i(31, 0, 0, 0);
    imem[5] = enc_i(23, 0, 8, 9);
    imem[6] = enc_i(31, 0, 0, 0);
    run_prog(0, 0, 200, cyc);
    check("t5_r1", 64'(rv(1)), 64'hFFFF_FFFF);
    check("t5_r7_skipped", 64'(rv(7)), 64'd0);
    check("t5_r8", 64'(rv(8)), 64'd9);
    check("t5_pc", 64'(dut.pc), 64'd6);

    // Call/return with a subroutine exercising r0, sll, sub, srl, slt
    clear_mem();
    imem[0]  = enc_i(23, 0, 1, 10);
    imem[1]  = enc_i(23, 0, 2, 20);
    imem[2]  = enc_i(22, 0, 0, 20);
    imem[3]  = enc_i(23, 0, 4, 4);
    imem[4]  = enc_r(30, 0, 0, 0, 0);
    imem[5]  = enc_i(31, 0, 0, 0);
    imem[20] = enc_r(0, 1, 2, 0, 0);
    imem[21] = enc_i(23, 0, 3, 4);
    imem[22] = enc_r(10, 0, 1, 5, 3);
    imem[23] = enc_r(1, 1, 2, 6, 0);
    imem[24] = enc_r(11, 0, 6, 7, 3);
    imem[25] = enc_r(24, 6, 1, 8, 0);
    imem[26] = enc_i(21, 31, 0, 0);
    run_prog(0, 0, 300, cyc);
    check("t6_r31", 64'(rv(31)), 64'd3);
    check("t6_r0", 64'(rv(0)), 64'd0);
    check("t6_r4", 64'(rv(4)), 64'd4);
    check("t6_sll", 64'(rv(5)), 64'd160);
    check("t6_sub", 64'(rv(6)), 64'hFFFF_FFF6);
    check("t6_srl", 64'(rv(7)), 64'h0FFF_FFFF);
    check("t6_slt", 64'(rv(8)), 64'd1);
    check("t6_pc", 64'(dut.pc), 64'd5);
    check("t6_retires", 64'(retire_cnt), 64'd13);

    // Reset while a store waits in MEM
    clear_mem();
    imem[0] = enc_i(23, 0, 1, 7);
    imem[1] = enc_i(13, 0, 1, 0);
    imem[2] = enc_i(31, 0, 0, 0);
    iwait = 0;
    dwait = 20;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (dmem_req) break;
    end
    check("t7_mem_reached", {63'd0, dmem_req}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("t7_dmem_req_rst", {63'd0, dmem_req}, 64'd0);
    check("t7_pc", 64'(dut.pc), 64'd0);
    check("t7_r1", 64'(rv(1)), 64'd0);
`ifdef VEDA_MC_CORE_PERF_EN
    check("t7_cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("t7_instr_cnt", 64'(instr_cnt), 64'd0);
`endif
    rst = 1'b0;
    #1;
    check("t7_dmem_req_after", {63'd0, dmem_req}, 64'd0);
    check("t7_imem_req_after", {63'd0, imem_req}, 64'd1);
    check("t7_no_store", 64'(st_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/veda_mc_core.md
Name: veda_mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle Veda datapath: same 6-bit-opcode ISA, executed by an explicit FSM.
- Fetches from a separate instruction memory and loads/stores to a separate data memory, each over a req/ready handshake, so wait-state memories are tolerated.
- Sits between the instruction ROM/RAM and the data RAM; exposes halt status and retirement to the testbench.

Parameters:
- XLEN, 32, datapath and register width (>=16).
- PC_W, 9, instruction address width; PC wraps modulo 2^PC_W.
- DA_W, 9, data address width; effective address truncated to DA_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (= PC).
- imem_ready  in  1  fetch accepted; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DA_W  effective address.
- dmem_wdata  out  XLEN  store data.
- dmem_ready  in  1  access complete; dmem_rdata valid for loads.
- dmem_rdata  in  XLEN  load data.
- halted  out  1  core stopped on HALT.
- retire  out  1  one-cycle pulse per retired instruction.

Behaviour:
- Reset is already decided as synchronous, active-high on rst; clock is clk.
- Reset values: PC=RESET_PC, all 32 registers=0, state=FETCH, all outputs 0.
- Reset mid-operation aborts the access in flight; req drops the next cycle.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: hold imem_req=1 and imem_addr stable until imem_ready. Latch the instruction, then go to DECODE.
- DECODE: read rs=[25:21], rt=[20:16] into operand registers.
- EXEC: ALU result, branch decision and effective address are computed. lw/sw go to MEM; everything else goes to WB.
- MEM: hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable until dmem_ready. Loads capture dmem_rdata. Then go to WB.
- WB: write the destination, update PC, pulse retire, go to FETCH.
- Latency with zero-wait memories (ready in the first req cycle): ALU/branch = 4 cycles; lw/sw = 5 cycles. Each memory wait cycle adds 1.
- Register 0 always reads 0; writes to it are discarded.
- Immediate imm=[15:0]: sign-extended for addi, lw, sw, branches; zero-extended for addiu, andi, ori, li, j.
- rd=[15:11] for R-type ops; rt for immediate ops.
- Opcodes:
  - 0 add, 1 sub, 2 addu, 3 subu; all wrap modulo 2^XLEN, no traps.
  - 4 addi, 5 addiu.
  - 6 and, 7 or, 8 andi, 9 ori.
  - 10 sll: rd = rt << reg[[10:6]]. 11 srl (logical): rd = rt >> reg[[10:6]]. Shift amount = low clog2(XLEN) bits of reg[[10:6]].
  - 12 lw: rt = mem[rs+sext(imm)]. 13 sw: mem[rs+sext(imm)] = rt.
  - 14 beq, 15 bne, 16 bgt, 17 bgte, 18 blt, 19 ble: signed compare of rs against rt. Taken -> PC = PC+1+sext(imm); not taken -> PC = PC+1.
  - 20 j: PC = imm.
  - 21 jr: PC = reg[rs][PC_W-1:0].
  - 22 jal: r31 = PC+1, PC = imm.
  - 23 li: rt = zext(imm).
  - 24 slt: rd = (signed rs < rt) ? 1 : 0.
  - 31 HALT: go to HALT; halted=1, retire pulses once, PC frozen. Only rst leaves HALT.
  - All other opcodes: NOP, retired, PC+1.
- A PC update past 2^PC_W-1 wraps to 0.

Optional Feature:
- Macro VEDA_MC_CORE_PERF_EN.
- When defined: adds output ports cycle_cnt (32) and instr_cnt (32).
  - cycle_cnt increments every non-HALT cycle.
  - instr_cnt increments on each retire.
  - Both clear on rst and saturate at 2^32-1.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Zero-wait memories; program "li r1,5; li r2,7; add r3,r1,r2; HALT" -> r3=12; retire pulses 4 times; halted=1 at cycle 16.
- imem_ready delayed 3 cycles on each fetch -> imem_addr and imem_req held stable throughout; same results; every instruction takes 3 extra cycles.
- "li r16,100; li r5,42; sw r5,4(r16); lw r6,4(r16)" -> dmem write to addr 104 with data 42; r6=42; dmem_we=0 on the load.
- Branch loop: r1=0, r2=3; "addi r1,r1,1; bne r1,r2,-2" -> loop body executes 3 times; final PC = loop end + 1. Signed blt with r1=-1, r2=1 is taken.
- jal to 20, then jr r31 -> r31 = caller PC+1; returns to the correct address. "add r0,r1,r2" leaves r0 reading 0.
- Assert rst during a MEM wait state -> dmem_req=0 the next cycle; registers 0; PC=RESET_PC; with VEDA_MC_CORE_PERF_EN, both counters = 0.
